// File: rtl/prio_rr_arbiter.sv
// Registered N-way arbiter: fixed priority (highest index wins) or round-robin below the last
// winner, with the grant held under a valid/ready handshake.
module prio_rr_arbiter #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot,
  output logic             busy
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [N-1:0]       gnt_onehot_q, gnt_onehot_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;

  logic [IDX_W-1:0]   base;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

  // Search base: in GRANT the winner is only used on a transfer, so bypass the accepted index.
  always_comb begin
    base = last_idx_q;
    if (state_q == StGrant) begin
      base = gnt_idx_q;
    end
    // Fixed priority is the round-robin search starting from base 0 (N-1 downwards).
    if (!mode) begin
      base = '0;
    end
  end

  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = 1; off <= int'(N); off++) begin
      cand = int'(base) - off;
      if (cand < 0) begin
        cand = cand + int'(N);
      end
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    last_idx_d   = last_idx_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d      = StGrant;
          gnt_idx_d    = win_idx;
          gnt_onehot_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
        end
      end
      StGrant: begin
        if (gnt_ready) begin
          last_idx_d = gnt_idx_q;
          if (win_found) begin
            gnt_idx_d    = win_idx;
            gnt_onehot_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
          end else begin
            state_d      = StIdle;
            gnt_onehot_d = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= StIdle;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      last_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
      last_idx_q   <= last_idx_d;
    end
  end

  assign gnt_valid  = (state_q == StGrant);
  assign busy       = (state_q == StGrant);
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;

endmodule
